// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state/size types and
// small decode helpers for the LSU controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_t;

  // funct3[1:0]=11 has no RV32 meaning; treat as word
  function automatic mem_size_t size_of(
    input logic [2:0] f3
  );
    if (f3[1:0] == 2'b00) return SZ_B;
    if (f3[1:0] == 2'b01) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic [3:0] wstrb_gen(
    input mem_size_t  sz,
    input logic [1:0] off
  );
    logic [3:0] base;
    unique case (sz)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return (sz == SZ_W) ? 4'hF : base << off;
  endfunction

  function automatic logic misaligned(
    input mem_size_t  sz,
    input logic [1:0] off
  );
    return ((sz == SZ_H) && off[0]) ||
           ((sz == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory request/response
// channel between the LSU (master) and memory.
interface lsu_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN/8-1:0] req_wstrb;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes
// and load byte/half extract with extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_load,
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_wdata,
  output logic [XLEN/8-1:0] st_wstrb,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   ld_data
);

  mem_size_t       st_sz;
  mem_size_t       ld_sz;
  logic [XLEN-1:0] ld_shift;
  logic            ld_sext;

  assign st_sz    = size_of(st_funct3);
  assign ld_sz    = size_of(ld_funct3);
  assign ld_shift = ld_raw >> {ld_off, 3'b000};
  assign ld_sext  = ~ld_funct3[2];

  // store: replicate into every lane; loads keep the bus quiet
  always_comb begin
    st_wdata = '0;
    st_wstrb = '0;
    if (!is_load) begin
      st_wstrb = wstrb_gen(st_sz, st_off);
      unique case (1'b1)
        st_sz == SZ_B: st_wdata = {4{st_data[7:0]}};
        st_sz == SZ_H: st_wdata = {2{st_data[15:0]}};
        default:       st_wdata = st_data;
      endcase
    end
  end

  // load: pick the addressed lane, then sign/zero extend
  always_comb begin
    ld_data = ld_raw;
    unique case (1'b1)
      ld_sz == SZ_B:
        ld_data = {{24{ld_sext & ld_shift[7]}},
                   ld_shift[7:0]};
      ld_sz == SZ_H:
        ld_data = {{16{ld_sext & ld_shift[15]}},
                   ld_shift[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-op-at-a-time load/store
// sequencer driving a valid/ready memory channel.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_en,
  input  logic              flush,
  input  logic              op_valid,
  input  logic              op_is_load,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [XLEN-1:0]   op_wdata,
  input  logic [4:0]        op_rd,
  lsu_ctrl_if.master        mem,
  output logic              lsu_busy,
  output logic              ld_valid,
  output logic [4:0]        ld_rd,
  output logic [XLEN-1:0]   ld_data,
  output logic              misalign
);

  lsu_state_t state;
  lsu_state_t next_state;

  logic accept;
  logic op_mis;
  logic start;
  logic kill;
  logic resp_take;
  logic wb_fire;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              we_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] wstrb_q;

  logic [XLEN-1:0]   st_wdata;
  logic [XLEN/8-1:0] st_wstrb;
  logic [XLEN-1:0]   ld_fmt;

  assign accept = (state == IDLE) & op_valid &
                  lsu_en & ~flush;
  assign op_mis = misaligned(size_of(op_funct3),
                             op_addr[1:0]);
  assign start  = accept & ~op_mis;

  assign resp_take = (state == WAIT) & mem.resp_valid;
  assign wb_fire   = resp_take & ~kill & ~flush;

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_load   (op_is_load),
    .st_funct3 (op_funct3),
    .st_off    (op_addr[1:0]),
    .st_data   (op_wdata),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (funct3_q),
    .ld_off    (addr_q[1:0]),
    .ld_raw    (mem.resp_rdata),
    .ld_data   (ld_fmt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // next state: stores retire on acceptance
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = REQ;
      REQ:
        if (mem.req_ready)
          next_state = we_q ? IDLE : WAIT;
      WAIT: if (mem.resp_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // request valid and stall toward fetch/issue
  always_comb begin
    mem.req_valid = (state == REQ);
    lsu_busy      = (state != IDLE) | accept;
  end

  assign mem.req_we    = we_q;
  assign mem.req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.req_wdata = wdata_q;
  assign mem.req_wstrb = wstrb_q;

  // capture the accepted op; held stable through REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else if (start) begin
      addr_q   <= op_addr;
      wdata_q  <= st_wdata;
      wstrb_q  <= st_wstrb;
      funct3_q <= op_funct3;
      rd_q     <= op_rd;
      we_q     <= ~op_is_load;
    end
  end

  // kill latches a flush seen while an op is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      kill <= 1'b0;
    else if (next_state == IDLE)
      kill <= 1'b0;
    else if (flush && (state != IDLE))
      kill <= 1'b1;
  end

  // registered writeback and misalign pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid <= 1'b0;
      ld_rd    <= '0;
      ld_data  <= '0;
      misalign <= 1'b0;
    end else begin
      ld_valid <= wb_fire;
      misalign <= accept & op_mis;
      if (wb_fire) begin
        ld_rd   <= rd_q;
        ld_data <= ld_fmt;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random op sequences
// checked against a transaction-level model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lsu_en = 1'b0;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_is_load = 1'b0;
  logic [2:0]  op_funct3 = '0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic [4:0]  op_rd = '0;
  logic        lsu_busy;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;

  lsu_ctrl_if #(.XLEN(32), .ADDR_W(32)) bus ();

  lsu_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsu_en     (lsu_en),
    .flush      (flush),
    .op_valid   (op_valid),
    .op_is_load (op_is_load),
    .op_funct3  (op_funct3),
    .op_addr    (op_addr),
    .op_wdata   (op_wdata),
    .op_rd      (op_rd),
    .mem        (bus),
    .lsu_busy   (lsu_busy),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  function automatic int nb(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(
    input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = nb(f3);
    return (n == 2 && a[0]) ||
           (n == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] m_strb(
    input bit ld, input logic [2:0] f3,
    input logic [31:0] a);
    logic [3:0] s;
    int n;
    int o;
    s = '0;
    n = nb(f3);
    o = int'(a[1:0]);
    if (!ld)
      for (int i = 0; i < 4; i++)
        if (i >= o && i < o + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(
    input bit ld, input logic [2:0] f3,
    input logic [31:0] wd);
    logic [31:0] w;
    int n;
    w = '0;
    n = nb(f3);
    if (!ld)
      for (int i = 0; i < 4; i++)
        w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] raw);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = nb(f3);
    v = raw >> (8 * int'(a[1:0]));
    if (n == 4) mask = 32'hFFFF_FFFF;
    else mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // one op end to end; fmode: 0 none, 1 flush
  // in REQ, 2 flush in WAIT, 3 flush with resp
  task automatic run_op(
    input bit ld, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [4:0] rd, input logic [31:0] rdata,
    input int stall, input int rdly, input int fmode,
    output logic [31:0] got, output int busy_n);
    bit          mis;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    logic [3:0]  e_st;
    int          rd_n;
    mis  = m_mis(f3, addr);
    e_wd = m_wdata(ld, f3, wd);
    e_st = m_strb(ld, f3, addr);
    e_ld = m_load(f3, addr, rdata);
    rd_n = (fmode == 2 && rdly == 0) ? 1 : rdly;
    busy_n = 0;
    got = '0;
    op_valid = 1'b1; lsu_en = 1'b1; flush = 1'b0;
    op_is_load = ld; op_funct3 = f3;
    op_addr = addr; op_wdata = wd; op_rd = rd;
    #1;
    n_vec++;
    if (lsu_busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept_busy: got %b want 1",
               lsu_busy);
    end
    if (lsu_busy === 1'b1) busy_n++;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_is_load = 1'($urandom);
    op_funct3 = 3'($urandom);
    op_addr = $urandom;
    op_wdata = $urandom;
    op_rd = 5'($urandom);
    #1;
    if (mis) begin
      n_vec++;
      if (misalign !== 1'b1 || bus.req_valid !== 1'b0 ||
          lsu_busy !== 1'b0 || ld_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mis_pulse: mis=%b req=%b busy=%b ldv=%b want 1 0 0 0",
                 misalign, bus.req_valid, lsu_busy, ld_valid);
      end
      return;
    end
    for (int c = 0; c <= stall; c++) begin
      bus.req_ready = (c == stall);
      bus.resp_valid = 1'($urandom);
      bus.resp_rdata = $urandom;
      flush = (fmode == 1 && c == 0);
      #1;
      n_vec++;
      if (bus.req_valid !== 1'b1 ||
          bus.req_we !== !ld ||
          bus.req_addr !== {addr[31:2], 2'b00} ||
          bus.req_wdata !== e_wd ||
          bus.req_wstrb !== e_st) begin
        n_err++;
        $display("FAIL req_fields: v=%b we=%b a=%h d=%h s=%b want 1 %b %h %h %b",
                 bus.req_valid, bus.req_we, bus.req_addr,
                 bus.req_wdata, bus.req_wstrb, !ld,
                 {addr[31:2], 2'b00}, e_wd, e_st);
      end
      n_vec++;
      if (lsu_busy !== 1'b1 || ld_valid !== 1'b0 ||
          misalign !== 1'b0) begin
        n_err++;
        $display("FAIL req_side: busy=%b ldv=%b mis=%b want 1 0 0",
                 lsu_busy, ld_valid, misalign);
      end
      if (lsu_busy === 1'b1) busy_n++;
      @(posedge clk); #1;
    end
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    flush = 1'b0;
    #1;
    if (!ld) begin
      n_vec++;
      if (bus.req_valid !== 1'b0 || lsu_busy !== 1'b0 ||
          ld_valid !== 1'b0) begin
        n_err++;
        $display("FAIL store_done: req=%b busy=%b ldv=%b want 0 0 0",
                 bus.req_valid, lsu_busy, ld_valid);
      end
      return;
    end
    for (int c = 0; c < rd_n; c++) begin
      flush = (fmode == 2 && c == 0);
      #1;
      n_vec++;
      if (bus.req_valid !== 1'b0 || lsu_busy !== 1'b1 ||
          ld_valid !== 1'b0) begin
        n_err++;
        $display("FAIL wait_state: req=%b busy=%b ldv=%b want 0 1 0",
                 bus.req_valid, lsu_busy, ld_valid);
      end
      if (lsu_busy === 1'b1) busy_n++;
      @(posedge clk); #1;
    end
    bus.resp_valid = 1'b1;
    bus.resp_rdata = rdata;
    flush = (fmode == 3);
    #1;
    n_vec++;
    if (lsu_busy !== 1'b1) begin
      n_err++;
      $display("FAIL resp_busy: got %b want 1", lsu_busy);
    end
    if (lsu_busy === 1'b1) busy_n++;
    @(posedge clk); #1;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = $urandom;
    flush = 1'b0;
    #1;
    got = ld_data;
    n_vec++;
    if (ld_valid !== (fmode == 0)) begin
      n_err++;
      $display("FAIL ld_valid: got %b want %b",
               ld_valid, fmode == 0);
    end
    if (fmode == 0) begin
      n_vec++;
      if (ld_data !== e_ld || ld_rd !== rd) begin
        n_err++;
        $display("FAIL ld_result: data=%h rd=%0d want %h %0d",
                 ld_data, ld_rd, e_ld, rd);
      end
    end
    n_vec++;
    if (lsu_busy !== 1'b0 || bus.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_done: busy=%b req=%b want 0 0",
               lsu_busy, bus.req_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    op_valid = 1'b1;
    lsu_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (bus.req_valid !== 1'b0 || bus.req_we !== 1'b0 ||
        bus.req_addr !== '0 || bus.req_wdata !== '0 ||
        bus.req_wstrb !== '0) begin
      n_err++;
      $display("FAIL reset_bus: v=%b we=%b a=%h d=%h s=%b want all 0",
               bus.req_valid, bus.req_we, bus.req_addr,
               bus.req_wdata, bus.req_wstrb);
    end
    n_vec++;
    if (ld_valid !== 1'b0 || ld_rd !== '0 ||
        ld_data !== '0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wb: ldv=%b rd=%0d d=%h mis=%b want all 0",
               ld_valid, ld_rd, ld_data, misalign);
    end
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (lsu_busy !== 1'b0 || bus.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b req=%b want 0 0",
               lsu_busy, bus.req_valid);
    end
  endtask

  task automatic test_lw();
    logic [31:0] got;
    int bn;
    run_op(1, 3'b010, 32'h100, 32'h0, 5'd5,
           32'hDEAD_BEEF, 0, 1, 0, got, bn);
    n_vec++;
    if (got !== 32'hDEAD_BEEF || bn != 4) begin
      n_err++;
      $display("FAIL lw_basic: data=%h busy_cycles=%0d want deadbeef 4",
               got, bn);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] got;
    int bn;
    run_op(1, 3'b000, 32'h103, 32'h0, 5'd1,
           32'h80FF_FF7F, 0, 0, 0, got, bn);
    n_vec++;
    if (got !== 32'hFFFF_FF80) begin
      n_err++;
      $display("FAIL lb_sext: got %h want ffffff80", got);
    end
    run_op(1, 3'b100, 32'h103, 32'h0, 5'd2,
           32'h80FF_FF7F, 1, 2, 0, got, bn);
    n_vec++;
    if (got !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL lbu_zext: got %h want 00000080", got);
    end
    run_op(1, 3'b001, 32'h102, 32'h0, 5'd3,
           32'h80FF_FF7F, 0, 1, 0, got, bn);
    n_vec++;
    if (got !== 32'hFFFF_80FF) begin
      n_err++;
      $display("FAIL lh_sext: got %h want ffff80ff", got);
    end
  endtask

  task automatic test_sb_stall();
    logic [31:0] got;
    int bn;
    run_op(0, 3'b000, 32'h201, 32'h1234_5678, 5'd0,
           32'h0, 3, 0, 0, got, bn);
    n_vec++;
    if (bn != 5) begin
      n_err++;
      $display("FAIL sb_busy_span: got %0d want 5", bn);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] got;
    int bn;
    run_op(1, 3'b010, 32'h102, 32'h0, 5'd7,
           32'h0, 0, 0, 0, got, bn);
    @(posedge clk); #1;
    n_vec++;
    if (misalign !== 1'b0 || bn != 1 ||
        bus.req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mis_once: mis=%b busy_cycles=%0d req=%b want 0 1 0",
               misalign, bn, bus.req_valid);
    end
  endtask

  task automatic test_no_accept();
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1;
      lsu_en = (k == 1);
      flush = (k == 1);
      op_is_load = 1'b1;
      op_funct3 = 3'b010;
      op_addr = 32'h502;
      #1;
      n_vec++;
      if (lsu_busy !== 1'b0) begin
        n_err++;
        $display("FAIL noacc_busy: got %b want 0", lsu_busy);
      end
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0; lsu_en = 1'b1;
      #1;
      n_vec++;
      if (bus.req_valid !== 1'b0 || misalign !== 1'b0) begin
        n_err++;
        $display("FAIL noacc_quiet: req=%b mis=%b want 0 0",
                 bus.req_valid, misalign);
      end
    end
  endtask

  task automatic test_flush_kill();
    logic [31:0] got;
    int bn;
    run_op(1, 3'b010, 32'h300, 32'h0, 5'd9,
           32'hCAFE_F00D, 1, 2, 2, got, bn);
    run_op(0, 3'b001, 32'h302, 32'hAAAA_5555, 5'd0,
           32'h0, 0, 0, 0, got, bn);
    run_op(1, 3'b001, 32'h306, 32'h0, 5'd10,
           32'h1234_8765, 2, 1, 1, got, bn);
    run_op(1, 3'b000, 32'h307, 32'h0, 5'd11,
           32'h1234_8765, 0, 1, 3, got, bn);
    run_op(1, 3'b101, 32'h30A, 32'h0, 5'd12,
           32'h9abc_0000, 0, 0, 0, got, bn);
    n_vec++;
    if (got !== 32'h0000_9ABC) begin
      n_err++;
      $display("FAIL after_kill: got %h want 00009abc", got);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    int bn;
    op_valid = 1'b1; lsu_en = 1'b1; flush = 1'b0;
    op_is_load = 1'b1; op_funct3 = 3'b010;
    op_addr = 32'h400; op_rd = 5'd4;
    bus.req_ready = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    n_vec++;
    if (bus.req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: req=%b want 1", bus.req_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.req_valid !== 1'b0 || lsu_busy !== 1'b0 ||
        ld_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_req: req=%b busy=%b ldv=%b want 0 0 0",
               bus.req_valid, lsu_busy, ld_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 3'b010, 32'h404, 32'h0, 5'd6,
           32'h0BAD_F00D, 0, 0, 0, got, bn);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ld_valid !== 1'b0 || ld_data !== '0) begin
      n_err++;
      $display("FAIL arst_wb: ldv=%b data=%h want 0 0",
               ld_valid, ld_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 3'b010, 32'h408, 32'h5555_AAAA, 5'd0,
           32'h0, 1, 0, 0, got, bn);
  endtask

  task automatic test_random();
    logic [31:0] got;
    logic [31:0] a;
    int bn;
    for (int k = 0; k < 80; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(1'($urandom), 3'($urandom), a, $urandom,
             5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ?
               $urandom_range(1, 3) : 0,
             got, bn);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_sb_stall();
    test_misalign();
    test_no_accept();
    test_flush_kill();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
